ow_rx_framer: RTL

- 1-wire receive framer between the bit-slot decoder and the CRC8 engine (x^8+x^5+x^4+1).
- Deserialises LSB-first bits into bytes.
- Issues one-cycle byte strobes to the CRC engine and clears it at frame start.
- After FRAME_LEN bytes (payload plus CRC byte), compares the engine's residue and reports frame pass/fail to the command layer.

---
 rtl/ow_rx_framer_pkg.sv | 19 +
 rtl/ow_rx_framer_if.sv | 32 +++
 rtl/ow_byte_deser.sv | 51 +++++
 rtl/ow_rx_framer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ow_rx_framer_pkg.sv
// Shared definitions for the 1-wire receive framer: FSM state encoding, byte width,
// default CRC residue and a small state-decoding helper.
package ow_rx_framer_pkg;

   localparam int OW_BYTE_W = 8;
   localparam logic [OW_BYTE_W-1:0] OW_CRC_RESIDUE_DEF = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RECV     = 2'd1,
      ST_WAIT_CRC = 2'd2,
      ST_DONE     = 2'd3
   } ow_state_e;

   function automatic logic ow_is_busy(input ow_state_e st);
      return (st == ST_RECV) || (st == ST_WAIT_CRC);
   endfunction

endpackage

// File: rtl/ow_rx_framer_if.sv
// Bit-slot decoder / CRC engine / command-layer signals of the 1-wire receive framer.
// master = the environment around the framer, slave = the framer itself.
interface ow_rx_framer_if;
   import ow_rx_framer_pkg::*;

   logic                 frame_start;
   logic                 bit_valid;
   logic                 bit_data;
   logic [OW_BYTE_W-1:0] crc_in;
   logic                 crc_clr;
   logic                 crc_en;
   logic [OW_BYTE_W-1:0] byte_data;
   logic [7:0]           byte_cnt;
   logic                 busy;
   logic                 frame_done;
   logic                 frame_ok;
   logic                 frame_err;
   logic                 timeout_err;

   modport master (
      output frame_start, bit_valid, bit_data, crc_in,
      input  crc_clr, crc_en, byte_data, byte_cnt, busy,
             frame_done, frame_ok, frame_err, timeout_err
   );

   modport slave (
      input  frame_start, bit_valid, bit_data, crc_in,
      output crc_clr, crc_en, byte_data, byte_cnt, busy,
             frame_done, frame_ok, frame_err, timeout_err
   );

endinterface

// File: rtl/ow_byte_deser.sv
// LSB-first byte deserialiser: shift register plus 3-bit bit counter; presents the
// assembled byte with a one-cycle o_byte_rdy pulse the cycle after its 8th bit.
module ow_byte_deser
   import ow_rx_framer_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_bit_en,
   input  logic                 i_bit,
   output logic [OW_BYTE_W-1:0] o_byte,
   output logic                 o_byte_rdy,
   output logic                 o_last_bit
);

   logic [OW_BYTE_W-1:0] r_shreg;
   logic [OW_BYTE_W-1:0] r_byte;
   logic [OW_BYTE_W-1:0] w_shreg_nxt;
   logic [2:0]           r_bit_cnt;
   logic                 r_byte_rdy;

   assign w_shreg_nxt = {i_bit, r_shreg[OW_BYTE_W-1:1]};
   assign o_last_bit  = i_bit_en && (r_bit_cnt == 3'd7);
   assign o_byte      = r_byte;
   assign o_byte_rdy  = r_byte_rdy;

   // Shift in accepted bits; the assembled byte is held until the next one completes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shreg    <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_byte     <= 8'h00;
         r_byte_rdy <= 1'b0;
      end else if (i_clr) begin
         r_shreg    <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_byte_rdy <= 1'b0;
      end else begin
         r_byte_rdy <= 1'b0;
         if (i_bit_en) begin
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte     <= w_shreg_nxt;
               r_byte_rdy <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ow_rx_framer.sv
// 1-wire receive framer: bytes to the CRC engine, residue check and frame verdict.
// Optional inter-bit timeout abort is enabled by defining OW_RX_TIMEOUT_EN.
module ow_rx_framer
   import ow_rx_framer_pkg::*;
#(
   parameter int                   FRAME_LEN   = 8,
   parameter logic [OW_BYTE_W-1:0] CRC_RESIDUE = OW_CRC_RESIDUE_DEF,
   parameter int                   TIMEOUT_CYC = 4096
) (
   input logic            i_clk,
   input logic            i_rst,
   ow_rx_framer_if.slave  io_bus
);

   localparam logic [7:0] LP_FRAME_LEN = 8'(FRAME_LEN);

   generate
      if (FRAME_LEN < 2 || FRAME_LEN > 255 || TIMEOUT_CYC < 2) begin : g_bad_param
         $error("ow_rx_framer: FRAME_LEN or TIMEOUT_CYC out of range");
      end
   endgenerate

   ow_state_e            r_state, w_state_nxt;
   logic                 r_crc_clr, w_crc_clr_nxt;
   logic [7:0]           r_byte_cnt, w_byte_cnt_nxt;
   logic                 r_busy;
   logic                 r_frame_done, w_frame_done_nxt;
   logic                 r_frame_ok, w_ok_nxt;
   logic                 r_frame_err, w_err_nxt;
   logic                 w_bit_en;
   logic                 w_last_bit;
   logic                 w_crc_en;
   logic [OW_BYTE_W-1:0] w_byte;

   // A bit colliding with frame_start belongs to no frame and is dropped.
   assign w_bit_en = io_bus.bit_valid && !io_bus.frame_start && (r_state == ST_RECV);

   ow_byte_deser u_deser (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (io_bus.frame_start),
      .i_bit_en   (w_bit_en),
      .i_bit      (io_bus.bit_data),
      .o_byte     (w_byte),
      .o_byte_rdy (w_crc_en),
      .o_last_bit (w_last_bit)
   );

`ifdef OW_RX_TIMEOUT_EN
   localparam int LP_TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [LP_TO_W-1:0] LP_TO_LIM = LP_TO_W'(TIMEOUT_CYC - 1);

   logic [LP_TO_W-1:0] r_idle_cnt;
   logic               r_timeout_err, w_to_nxt;
   logic               w_timeout;

   assign w_timeout = (r_idle_cnt == LP_TO_LIM);

   // Cycles since the last accepted bit (or frame start); the verdict lands as it reaches TIMEOUT_CYC.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idle_cnt <= '0;
      end else if (io_bus.frame_start || io_bus.bit_valid) begin
         r_idle_cnt <= LP_TO_W'(1);
      end else if (r_state == ST_RECV) begin
         r_idle_cnt <= r_idle_cnt + LP_TO_W'(1);
      end
   end
`endif

   // Next-state and next-output decode; frame_start overrides every state.
   always_comb begin
      w_state_nxt      = r_state;
      w_crc_clr_nxt    = 1'b0;
      w_byte_cnt_nxt   = r_byte_cnt;
      w_frame_done_nxt = 1'b0;
      w_ok_nxt         = r_frame_ok;
      w_err_nxt        = r_frame_err;
`ifdef OW_RX_TIMEOUT_EN
      w_to_nxt         = r_timeout_err;
`endif
      if (io_bus.frame_start) begin
         w_state_nxt    = ST_RECV;
         w_crc_clr_nxt  = 1'b1;
         w_byte_cnt_nxt = 8'd0;
         w_ok_nxt       = 1'b0;
         w_err_nxt      = 1'b0;
`ifdef OW_RX_TIMEOUT_EN
         w_to_nxt       = 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            ST_RECV: begin
               if (w_last_bit) begin
                  w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                  if (w_byte_cnt_nxt == LP_FRAME_LEN) begin
                     w_state_nxt = ST_WAIT_CRC;
                  end else begin
                     w_state_nxt = ST_RECV;
                  end
               end
`ifdef OW_RX_TIMEOUT_EN
               else if (w_timeout) begin
                  w_state_nxt      = ST_DONE;
                  w_frame_done_nxt = 1'b1;
                  w_err_nxt        = 1'b1;
                  w_to_nxt         = 1'b1;
               end
`endif
               else begin
                  w_state_nxt = ST_RECV;
               end
            end
            // crc_in reflects the last byte only once its crc_en strobe has gone.
            ST_WAIT_CRC: begin
               if (!w_crc_en) begin
                  w_state_nxt      = ST_DONE;
                  w_frame_done_nxt = 1'b1;
                  w_ok_nxt         = (io_bus.crc_in == CRC_RESIDUE);
                  w_err_nxt        = (io_bus.crc_in != CRC_RESIDUE);
               end else begin
                  w_state_nxt = ST_WAIT_CRC;
               end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_crc_clr    <= 1'b0;
         r_byte_cnt   <= 8'd0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_ok   <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef OW_RX_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_crc_clr    <= w_crc_clr_nxt;
         r_byte_cnt   <= w_byte_cnt_nxt;
         r_busy       <= ow_is_busy(w_state_nxt);
         r_frame_done <= w_frame_done_nxt;
         r_frame_ok   <= w_ok_nxt;
         r_frame_err  <= w_err_nxt;
`ifdef OW_RX_TIMEOUT_EN
         r_timeout_err <= w_to_nxt;
`endif
      end
   end

   assign io_bus.crc_clr    = r_crc_clr;
   assign io_bus.crc_en     = w_crc_en;
   assign io_bus.byte_data  = w_byte;
   assign io_bus.byte_cnt   = r_byte_cnt;
   assign io_bus.busy       = r_busy;
   assign io_bus.frame_done = r_frame_done;
   assign io_bus.frame_ok   = r_frame_ok;
   assign io_bus.frame_err  = r_frame_err;
`ifdef OW_RX_TIMEOUT_EN
   assign io_bus.timeout_err = r_timeout_err;
`else
   assign io_bus.timeout_err = 1'b0;
`endif

endmodule
